// File: rtl/ascii_arb_pkg.sv
// Shared types and default constants for the ASCII write arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ascii_arb_pkg;

    localparam int SCREEN_CELLS = 4800;
    localparam int SCREEN_COLS  = 80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DBG = 1'b1
    } requester_t;

endpackage

// File: rtl/ascii_write_fifo.sv
// Small synchronous FIFO buffering CPU character writes.
// Latency: a pushed entry is visible at the head (and in count) one cycle after the push.
// Backpressure: full blocks pushes; pop on empty is ignored; push+pop keeps count unchanged.
module ascii_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 45
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ascii_write_arbiter.sv
// Arbitrates CPU (FIFO-buffered) and debug writes onto the character controller's write port.
// Latency: grant -> write_en for HOLD_CYCLES cycles starting the next cycle, then one gap cycle.
// Backpressure: cpu_ready low when the FIFO is full; dbg_valid is held until a one-cycle dbg_ready.
module ascii_write_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int SCREEN_CELLS = ascii_arb_pkg::SCREEN_CELLS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_valid,
    output logic                          cpu_ready,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_data,
    input  logic                          dbg_valid,
    output logic                          dbg_ready,
    input  logic [ADDR_W-1:0]             dbg_addr,
    input  logic [DATA_W-1:0]             dbg_data,
    output logic                          ascii_write_en,
    output logic [ADDR_W-1:0]             ascii_write_address,
    output logic [DATA_W-1:0]             ascii_input,
    output logic                          range_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    import ascii_arb_pkg::*;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    arb_state_t               state;
    arb_state_t               state_next;
    requester_t               last_grant;
    logic [HOLD_W-1:0]        hold_cnt;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic                     grant_cpu;
    logic                     grant_dbg;
    logic                     grant_any;
    logic                     grant_bad;
    logic [ADDR_W-1:0]        grant_addr;
    logic [DATA_W-1:0]        grant_data;

    ascii_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_valid),
        .push_data ({cpu_addr, cpu_data}),
        .pop       (grant_cpu),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign head_addr = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign head_data = fifo_head[DATA_W-1:0];
    assign cpu_ready = !fifo_full;

    // Round-robin arbitration only in IDLE: on a tie the requester not granted last time wins.
    assign grant_cpu  = (state == IDLE) && !fifo_empty && (!dbg_valid || last_grant == DBG);
    assign grant_dbg  = (state == IDLE) && dbg_valid && !grant_cpu;
    assign grant_any  = grant_cpu || grant_dbg;
    assign dbg_ready  = grant_dbg;
    assign grant_addr = grant_cpu ? head_addr : dbg_addr;
    assign grant_data = grant_cpu ? head_data : dbg_data;
    assign grant_bad  = 32'(grant_addr) >= 32'(SCREEN_CELLS);
    assign busy       = (state != IDLE) || !fifo_empty;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: a good grant starts a write; out-of-range grants are swallowed in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any && !grant_bad) state_next = WRITE;
            WRITE:   if (hold_cnt == HOLD_LAST)   state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Hold counter restarts whenever we are outside WRITE so each write gets the full hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 hold_cnt <= '0;
        else if (state != WRITE) hold_cnt <= '0;
        else                     hold_cnt <= hold_cnt + 1'b1;
    end

    // Output registers: strobe tracks the WRITE state, address/data latch only on a good grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant          <= DBG;
            ascii_write_en      <= 1'b0;
            ascii_write_address <= '0;
            ascii_input         <= '0;
            range_error         <= 1'b0;
        end else begin
            ascii_write_en <= (state_next == WRITE);
            if (grant_any) begin
                last_grant <= grant_cpu ? CPU : DBG;
                if (grant_bad) begin
                    range_error <= 1'b1;
                end else begin
                    ascii_write_address <= grant_addr;
                    ascii_input         <= grant_data;
                end
            end
        end
    end

endmodule
